// File: rtl/fir_dline_ctrl.sv
// fir_dline_ctrl -- circular delay-line controller for the W4823 FIR datapath.
// Writes each accepted sample at the head of a circular buffer held in an
// external single-port SRAM (registered qout), then streams the newest TAPS
// samples, newest first, to the MAC through a 2-entry skid FIFO that absorbs
// the SRAM read latency and output backpressure.
// Optional feature: define DLINE_CLEAR_EN to zero the whole SRAM after every
// reset before the first sample is accepted.
module fir_dline_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_wr,
    input  logic [DATA_WIDTH-1:0] sram_qout
);

    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(TAPS - 1);

    typedef enum logic [2:0] {CLEAR, IDLE, WRITE, READ, DRAIN} state_t;

`ifdef DLINE_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] head;       // next write address
    logic [ADDR_WIDTH-1:0] base;       // address of the newest sample
    logic [ADDR_WIDTH-1:0] k;          // tap index of the next read
    logic [ADDR_WIDTH-1:0] clr_addr;   // sweep pointer used by CLEAR
    logic [DATA_WIDTH-1:0] sample;
    logic                  inflight;   // a read was issued last cycle
    logic                  tag;        // last flag travelling with that read

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;

    logic                  push, pop, issue;
    logic [2:0]            occupancy;

    // Handshake terms: a read may issue only if its data is guaranteed a FIFO slot.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        push      = inflight;
        pop       = (count != 2'd0) && m_ready;
        occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue     = (state == READ) && (occupancy < 3'd2);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= RESET_STATE;
        else     state <= state_nxt;
    end

    // Next state and SRAM/input-side outputs; everything held quiet during reset.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        sram_wr   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        case (state)
            CLEAR: begin
                sram_wr   = 1'b1;
                sram_addr = clr_addr;
                if (clr_addr == '1) state_nxt = IDLE;
            end
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) state_nxt = WRITE;
            end
            WRITE: begin
                sram_wr   = 1'b1;
                sram_addr = head;
                sram_din  = sample;
                state_nxt = READ;
            end
            READ: begin
                if (issue) begin
                    sram_addr = base - k;
                    if (k == LAST_K) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the final beat is leaving and nothing is in flight.
                if (occupancy == 3'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            s_ready   = 1'b0;
            sram_wr   = 1'b0;
            sram_addr = '0;
            sram_din  = '0;
        end
    end

    // Pointers, tap index and read-tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            base     <= '0;
            k        <= '0;
            clr_addr <= '0;
            sample   <= '0;
            inflight <= 1'b0;
            tag      <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
            if (state == IDLE && s_valid) sample <= s_data;
            if (state == WRITE) begin
                base <= head;
                head <= head + 1'b1;
                k    <= '0;
            end
            if (issue) begin
                tag <= (k == LAST_K);
                k   <= k + 1'b1;
            end
        end
    end

    // Skid FIFO occupancy and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Skid FIFO storage, captured one cycle after each read issue.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count gates every read of it, so stale entries are never visible.
        if (push) begin
            fifo_data[wr_ptr] <= sram_qout;
            fifo_last[wr_ptr] <= tag;
        end
    end

    assign m_valid = (count != 2'd0);
    assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last  = m_valid && fifo_last[rd_ptr];

endmodule

// File: doc/fir_dline_ctrl.md
# fir_dline_ctrl

Circular delay-line controller for the W4823 FIR datapath. It is the initiator side of the behavioural single-port SRAM: it drives that macro's `addr`/`din`/`wr` and consumes its registered `qout`. Each accepted input sample is written at the head pointer. The block then streams the most recent `TAPS` samples, newest to oldest, to the MAC stage over a valid/ready port. It absorbs the SRAM's one-cycle read latency and output backpressure with a 2-entry skid buffer.

## Interface
- `ADDR_WIDTH`, default 4: SRAM address width; DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 16: sample width.
- `TAPS`, default 16: samples streamed per input; legal range 1..DEPTH.

- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `s_data` in DATA_WIDTH: input sample.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: controller accepts a sample.
- `m_data` out DATA_WIDTH: delay-line sample to MAC.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: MAC accepts.
- `m_last` out 1: marks tap TAPS-1, the oldest sample.
- `sram_addr` out ADDR_WIDTH: to SRAM `addr`.
- `sram_din` out DATA_WIDTH: to SRAM `din`.
- `sram_wr` out 1: to SRAM `wr`.
- `sram_qout` in DATA_WIDTH: from SRAM `qout`; valid the cycle after a read is issued.

## Operation
- **States:** CLEAR (macro only), IDLE, WRITE, READ, DRAIN.
- **Registered state:**
  - `head` (ADDR_WIDTH): next write address.
  - `base`: address just written.
  - `k`: tap index, 0..TAPS-1.
  - `inflight` (1 bit).
  - Skid FIFO, 2 entries, carrying data plus a last flag.
- **IDLE**
  - `s_ready`=1.
  - On `s_valid&s_ready`: latch `s_data`, go to WRITE.
- **WRITE** (1 cycle)
  - Drives `sram_wr`=1, `sram_addr`=`head`, `sram_din`=sample.
  - Sets `base`=`head` and `head`=`head`+1 (mod DEPTH, natural wrap).
  - Sets `k`=0, then goes to READ.
- **READ**
  - Issue condition: `count + inflight - pop < 2`, where pop = `m_valid&m_ready`.
  - On issue: drive `sram_wr`=0 and `sram_addr`=`base` − `k` (mod DEPTH), set `inflight`=1, tag last = (`k`==TAPS-1), increment `k`.
  - After issuing `k`=TAPS-1, go to DRAIN.
- **Read return:** when `inflight`, the next cycle pushes `sram_qout` and its tag into the FIFO.
- **DRAIN:** when the FIFO is empty and `inflight`=0, go to IDLE.
- **Outputs:**
  - `m_valid` = FIFO non-empty; `m_data`/`m_last` = FIFO head.
  - `s_ready` is 1 only in IDLE. Input never overlaps a read burst.
- **Simultaneous events:** push and pop in the same cycle are legal; count is unchanged.
- **Reset (any state, including mid-burst):**
  - State → CLEAR (macro) or IDLE.
  - `head`, `k`, `inflight`, FIFO cleared.
  - In-flight SRAM data is discarded. SRAM contents are untouched apart from CLEAR.
- **Reset values:** `s_ready`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `sram_wr`=0, `sram_addr`=0, `sram_din`=0.
- Never drive `sram_wr`=1 while `inflight`=1. A write outputs X on `qout`.

## Timing
- **Acceptance:** handshake at edge E0; WRITE during E0→E1; the SRAM stores at E1.
- **First read:** issued E1→E2; `qout` valid E2→E3; pushed at E3.
- **First beat:** `m_valid`=1 in the cycle after E3, i.e. 3 cycles after acceptance.
- **Throughput:** with `m_ready`=1, one beat per cycle; last beat in cycle E3+TAPS-1.
- **Return to IDLE:** one cycle after the last handshake; `s_ready` rises the following cycle.
- **Input rate:** minimum sample period is TAPS+4 cycles.
- **Backpressure:** with `m_ready`=0, at most 2 beats are buffered and no read issues. No beat is lost or duplicated.

## Configuration
- **`DLINE_CLEAR_EN` defined:**
  - After reset, CLEAR writes 0 to addresses 0..DEPTH-1, one per cycle (`sram_wr`=1), then goes to IDLE.
  - `s_ready` stays 0 for DEPTH cycles.
  - Taps older than the samples received read as 0.
- **Not defined:**
  - Reset goes directly to IDLE; `s_ready`=1 on the first cycle after reset.
  - Unwritten taps return SRAM power-up contents (X in simulation).

## Test plan
- **Basic order:** TAPS=4, DEPTH=16, macro on. After the clear, push 1, 2, 3 (`m_ready`=1) → after sample 3 the bench sees `m_data` 3, 2, 1, 0, with `m_last` only on 0. The first beat comes 3 cycles after acceptance.
- **Wrap-around:** push 1..20 → the final burst is 20, 19, 18, 17. Write addresses go 15→0→…→3, and `head`=4.
- **Backpressure:** TAPS=16, `m_ready` pattern 1,0,0,1 repeating → exactly 16 beats in strict newest-to-oldest order. `inflight`+count never exceeds 2, and `s_ready` stays 0 until after the last beat.
- **Reset mid-burst:** assert `rst` after beat 2 of a burst. All outputs take their reset values immediately. CLEAR repeats (DEPTH cycles of `sram_wr`). The next sample 7 yields 7, 0, 0, 0.
- **Macro off:** after reset `s_ready`=1 within 1 cycle and no SRAM write occurs. Push 5 → first beat `m_data`=5; older taps are not checked.
- **Input stall:** hold `s_valid`=1 throughout → samples are accepted only in IDLE, spaced TAPS+4 cycles apart. No write happens while `inflight`=1.
